frame_scanout: RTL



---
 rtl/scanout_pkg.sv | 14 +
 rtl/scanout_delay.sv | 29 ++
 rtl/frame_scanout.sv | 132 +++++++++++++
 3 files changed

// File: rtl/scanout_pkg.sv
// Shared types and defaults for the frame scanout read stage.
package scanout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         ADDR_W_DFLT  = 19;
  localparam int         MEM_LAT_DFLT = 2;
  localparam logic [7:0] BORDER_LEVEL = 8'h80;

endpackage

// File: rtl/scanout_delay.sv
// Sideband delay line: carries per-pixel flags alongside the memory read so
// they line up with the returned data. The keep mask is ANDed into every
// stage on each shift, which lets the parent selectively drop flags.
module scanout_delay #(
  parameter int DATA_W = 3,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] keep,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] pipe [STAGES];

  // Shift flags one stage per clock; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din & keep;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1] & keep;
    end
  end

  assign dout = pipe[STAGES-1];

endmodule

// File: rtl/frame_scanout.sv
// Display-side read stage: turns timing-generator coordinates into image
// memory reads and realigns the returned samples as grayscale pixels.
// Row addresses are accumulated, so no multiplier is needed.
// Optional build macro SCANOUT_BORDER_EN: active pixels outside the image
// window show BORDER_LEVEL instead of black.
module frame_scanout
  import scanout_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int MEM_LAT = MEM_LAT_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              active,
  input  logic              frame_start,
  input  logic [15:0]       dimensiones,
  input  logic [ADDR_W-1:0] base_adr,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              pixel_valid,
  output logic              frame_done
);

`ifdef SCANOUT_BORDER_EN
  localparam logic [7:0] FILL = BORDER_LEVEL;
`else
  localparam logic [7:0] FILL = 8'h00;
`endif

  state_t            state, state_next;
  logic [7:0]        w_lat, h_lat, w_next, h_next;
  logic [ADDR_W-1:0] row_base, row_base_next;
  logic [ADDR_W-1:0] adr_p0;
  logic              hit_p0, row_end_p0, last_p0, empty_p0, abort_p0;
  logic [2:0]        sb_p0, sb_keep, sb_tail;
  logic              hit_tail, act_tail, last_tail;

  // Window hit detection, row accumulation and frame sequencing.
  always_comb begin
    state_next    = state;
    w_next        = w_lat;
    h_next        = h_lat;
    row_base_next = row_base;
    hit_p0     = (state == SCAN) && active && !frame_start &&
                 (x < {2'b00, w_lat}) && (y < {2'b00, h_lat});
    row_end_p0 = hit_p0 && (x == ({2'b00, w_lat} - 10'd1));
    last_p0    = row_end_p0 && (y == ({2'b00, h_lat} - 10'd1));
    empty_p0   = frame_start &&
                 ((dimensiones[15:8] == 8'd0) || (dimensiones[7:0] == 8'd0));
    abort_p0   = frame_start && (state == SCAN);
    adr_p0     = row_base + {{(ADDR_W-10){1'b0}}, x};
    if (frame_start) begin
      w_next        = dimensiones[15:8];
      h_next        = dimensiones[7:0];
      row_base_next = base_adr;
      state_next    = empty_p0 ? DONE : SCAN;
    end else if (row_end_p0) begin
      row_base_next = row_base + {{(ADDR_W-8){1'b0}}, w_lat};
      if (last_p0) state_next = DONE;
    end
  end

  // Frame control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      w_lat    <= 8'd0;
      h_lat    <= 8'd0;
      row_base <= '0;
    end else begin
      state    <= state_next;
      w_lat    <= w_next;
      h_lat    <= h_next;
      row_base <= row_base_next;
    end
  end

  // ---- stage p1: registered memory request ----
  // The address only moves on a hit so the bus stays quiet between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd  <= 1'b0;
      mem_adr <= '0;
    end else begin
      mem_rd <= hit_p0;
      if (hit_p0) mem_adr <= adr_p0;
    end
  end

  // Restarting mid-frame keeps draining old pixels but drops their last tag.
  assign sb_p0   = {hit_p0, active, last_p0};
  assign sb_keep = {2'b11, ~abort_p0};

  scanout_delay #(
    .DATA_W (3),
    .STAGES (MEM_LAT + 1)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (sb_p0),
    .keep  (sb_keep),
    .dout  (sb_tail)
  );

  assign hit_tail  = sb_tail[2];
  assign act_tail  = sb_tail[1];
  assign last_tail = sb_tail[0] & ~abort_p0;

  // ---- stage p(MEM_LAT+2): registered pixel output ----
  // An empty frame reports completion right after its frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r           <= 8'h00;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      pixel_valid <= hit_tail;
      r           <= hit_tail ? mem_data : (act_tail ? FILL : 8'h00);
      frame_done  <= (hit_tail && last_tail) || empty_p0;
    end
  end

  assign g = r;
  assign b = r;

endmodule
